// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-back, write-allocate data cache for the MEM stage.
// Misses write back a dirty victim and refill the line one word per memory handshake.
`default_nettype none

module dcache_ctrl #(
  parameter int LINES      = 64,
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  input  logic [2:0]        cpu_f3,
  output logic [31:0]       cpu_rdata,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
);

  localparam int c_WSEL_W = $clog2(LINE_WORDS);
  localparam int c_OFF_W  = c_WSEL_W + 2;
  localparam int c_IDX_W  = $clog2(LINES);
  localparam int c_TAG_W  = ADDR_W - c_OFF_W - c_IDX_W;
  localparam logic [c_WSEL_W-1:0] c_LAST = c_WSEL_W'(LINE_WORDS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WB   = 2'd1;
  localparam logic [1:0] S_FILL = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]          r_state, w_next;
  logic [c_WSEL_W-1:0] r_cnt;
  logic [LINES-1:0]    r_valid, r_dirty;
  logic [c_TAG_W-1:0]  r_tag  [LINES];
  logic [31:0]         r_data [LINES*LINE_WORDS];
  logic [31:0]         r_hit_cnt, r_miss_cnt;

  logic [c_WSEL_W-1:0]         w_word;
  logic [c_IDX_W-1:0]          w_idx;
  logic [c_TAG_W-1:0]          w_tag;
  logic [c_IDX_W+c_WSEL_W-1:0] w_line_sel, w_fill_sel;
  logic w_req, w_hit, w_miss, w_xfer_ack, w_fill_last, w_store_en, w_hit_evt;
  logic [3:0]  w_wmask;
  logic [31:0] w_wword;

  assign w_word     = cpu_addr[c_OFF_W-1:2];
  assign w_idx      = cpu_addr[c_OFF_W +: c_IDX_W];
  assign w_tag      = cpu_addr[ADDR_W-1 -: c_TAG_W];
  assign w_line_sel = {w_idx, w_word};
  assign w_fill_sel = {w_idx, r_cnt};

  // Requests are masked while reset is held so stall cannot rise during reset.
  assign w_req       = (cpu_rd | cpu_wr) & rst;
  assign w_hit       = w_req & r_valid[w_idx] & (r_tag[w_idx] == w_tag);
  assign w_miss      = (r_state == S_IDLE) & w_req & ~w_hit;
  assign w_xfer_ack  = mem_ack & ((r_state == S_WB) | (r_state == S_FILL));
  assign w_fill_last = (r_state == S_FILL) & mem_ack & (r_cnt == c_LAST);
  assign w_hit_evt   = ((r_state == S_IDLE) & w_hit) | (r_state == S_DONE);
  assign w_store_en  = cpu_wr & w_hit_evt;

  assign cpu_rdata = r_data[w_line_sel];
  assign hit_cnt   = r_hit_cnt;
  assign miss_cnt  = r_miss_cnt;

  always_comb begin
    w_wmask = 4'hF;
    w_wword = cpu_wdata;
    case (cpu_f3)
      3'b000: begin
        w_wmask = 4'b0001 << cpu_addr[1:0];
        w_wword = {4{cpu_wdata[7:0]}};
      end
      3'b001: begin
        w_wmask = cpu_addr[1] ? 4'b1100 : 4'b0011;
        w_wword = {2{cpu_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_miss) w_next = (r_valid[w_idx] & r_dirty[w_idx]) ? S_WB : S_FILL;
      S_WB:   if (mem_ack && r_cnt == c_LAST) w_next = S_FILL;
      S_FILL: if (mem_ack && r_cnt == c_LAST) w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    stall     = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (r_state)
      S_IDLE: stall = w_miss;
      S_WB: begin
        stall     = 1'b1;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {r_tag[w_idx], w_idx, r_cnt, 2'b00};
        mem_wdata = r_data[w_fill_sel];
      end
      S_FILL: begin
        stall    = 1'b1;
        mem_req  = 1'b1;
        mem_addr = {w_tag, w_idx, r_cnt, 2'b00};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt      <= '0;
      r_valid    <= '0;
      r_dirty    <= '0;
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      if (w_miss)          r_cnt <= '0;
      else if (w_xfer_ack) r_cnt <= r_cnt + 1'b1;
      if (w_fill_last) begin
        r_valid[w_idx] <= 1'b1;
        r_dirty[w_idx] <= 1'b0;
      end else if (w_store_en) begin
        r_dirty[w_idx] <= 1'b1;
      end
      if (w_hit_evt && r_hit_cnt != 32'hFFFF_FFFF)  r_hit_cnt  <= r_hit_cnt + 32'd1;
      if (w_miss && r_miss_cnt != 32'hFFFF_FFFF)    r_miss_cnt <= r_miss_cnt + 32'd1;
    end
  end

  // Line data and tags carry no reset; valid bits guard them.
  always_ff @(posedge clk) begin
    if ((r_state == S_FILL) && mem_ack) begin
      r_data[w_fill_sel] <= mem_rdata;
      if (r_cnt == c_LAST) r_tag[w_idx] <= w_tag;
    end else if (w_store_en) begin
      for (int b = 0; b < 4; b++) begin
        if (w_wmask[b]) r_data[w_line_sel][8*b +: 8] <= w_wword[8*b +: 8];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: scoreboard bench for dcache_ctrl with a word-serial memory responder.
`default_nettype none

module tb_dcache_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_rd = 1'b0, cpu_wr = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic [2:0]  cpu_f3 = 3'b010;
  logic [31:0] cpu_rdata;
  logic        stall, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic [31:0] hit_cnt, miss_cnt;

  dcache_ctrl #(.LINES(64), .LINE_WORDS(4), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_f3(cpu_f3), .cpu_rdata(cpu_rdata), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } xfer_t;

  xfer_t       exp_q[$];
  logic [31:0] mem [0:4095];
  int          total = 0;
  int          bad = 0;
  int          ack_delay = 0;
  int          wait_cnt = 0;
  int          stab_err = 0;
  logic [31:0] h_addr, h_wd;

  function automatic logic [31:0] pat(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  task automatic push_line(input logic we, input logic [31:0] base);
    xfer_t x;
    for (int w = 0; w < 4; w++) begin
      x.we   = we;
      x.addr = base + 32'(4 * w);
      x.data = pat(x.addr);
      exp_q.push_back(x);
    end
  endtask

  // Memory model: acks after ack_delay waiting cycles, scoreboards every transfer.
  initial begin
    xfer_t e;
    for (int i = 0; i < 4096; i++) mem[i] = pat(32'(i * 4));
    mem[64] = 32'hDEADBEEF;
    forever begin
      @(negedge clk);
      if (mem_req === 1'b1) begin
        if (wait_cnt == 0) begin
          h_addr = mem_addr;
          h_wd   = mem_wdata;
        end else if (mem_addr !== h_addr || mem_wdata !== h_wd || stall !== 1'b1) begin
          stab_err++;
        end
        if (wait_cnt >= ack_delay) begin
          mem_ack  = 1'b1;
          wait_cnt = 0;
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL xfer unexpected: we=%0b addr=%h", mem_we, mem_addr);
          end else begin
            e = exp_q.pop_front();
            if (mem_we !== e.we || mem_addr !== e.addr || (e.we && mem_wdata !== e.data)) begin
              bad++;
              $display("FAIL xfer: got we=%0b addr=%h wdata=%h, want we=%0b addr=%h wdata=%h",
                       mem_we, mem_addr, mem_wdata, e.we, e.addr, e.data);
            end
          end
          if (mem_we) mem[mem_addr[13:2]] = mem_wdata;
          else        mem_rdata = mem[mem_addr[13:2]];
        end else begin
          mem_ack = 1'b0;
          wait_cnt++;
        end
      end else begin
        mem_ack  = 1'b0;
        wait_cnt = 0;
      end
    end
  end

  task automatic access(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                        input logic [2:0] f3, output int stalls, output logic [31:0] rd);
    stalls = 0;
    @(negedge clk);
    cpu_rd = !wr; cpu_wr = wr; cpu_addr = a; cpu_wdata = wd; cpu_f3 = f3;
    #1;
    while (stall === 1'b1 && stalls < 500) begin
      @(negedge clk); #1;
      stalls++;
    end
    if (stalls >= 500) begin
      total++; bad++;
      $display("FAIL access timeout: addr=%h stall still %0b after %0d cycles", a, stall, stalls);
    end
    rd = cpu_rdata;
    @(posedge clk); #1;
    cpu_rd = 1'b0; cpu_wr = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    total++; if ({stall, mem_req, mem_we} !== 3'b000) begin bad++; $display("FAIL reset ctl: got %b want 000", {stall, mem_req, mem_we}); end
    total++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin bad++; $display("FAIL reset bus: got addr=%h wdata=%h want 0", mem_addr, mem_wdata); end
    total++; if (hit_cnt !== 32'h0 || miss_cnt !== 32'h0) begin bad++; $display("FAIL reset cnt: got hit=%0d miss=%0d want 0", hit_cnt, miss_cnt); end
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_cold_load;
    int s; logic [31:0] r;
    push_line(1'b0, 32'h100);
    access(1'b0, 32'h100, 32'h0, 3'b010, s, r);
    total++; if (r !== 32'hDEADBEEF) begin bad++; $display("FAIL cold rdata: got %h want DEADBEEF", r); end
    total++; if (s !== 5) begin bad++; $display("FAIL cold stalls: got %0d want 5", s); end
    total++; if (miss_cnt !== 1 || hit_cnt !== 1) begin bad++; $display("FAIL cold cnt: got hit=%0d miss=%0d want 1/1", hit_cnt, miss_cnt); end
    total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL cold xfers left: got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_store_hit;
    int s; logic [31:0] r;
    access(1'b1, 32'h101, 32'h0000_0055, 3'b000, s, r);
    total++; if (s !== 0) begin bad++; $display("FAIL sb stalls: got %0d want 0", s); end
    access(1'b0, 32'h100, 32'h0, 3'b010, s, r);
    total++; if (r !== 32'hDEAD55EF) begin bad++; $display("FAIL sb rdata: got %h want DEAD55EF", r); end
    total++; if (s !== 0 || hit_cnt !== 3) begin bad++; $display("FAIL sb hit: got stalls=%0d hit=%0d want 0/3", s, hit_cnt); end
  endtask

  task automatic test_dirty_evict;
    int s; logic [31:0] r; xfer_t x;
    x.we = 1'b1; x.addr = 32'h100; x.data = 32'hDEAD55EF;
    exp_q.push_back(x);
    for (int w = 1; w < 4; w++) begin
      x.addr = 32'h100 + 32'(4 * w);
      x.data = pat(x.addr);
      exp_q.push_back(x);
    end
    push_line(1'b0, 32'h1100);
    access(1'b0, 32'h1100, 32'h0, 3'b010, s, r);
    total++; if (r !== pat(32'h1100)) begin bad++; $display("FAIL evict rdata: got %h want %h", r, pat(32'h1100)); end
    total++; if (s !== 9) begin bad++; $display("FAIL evict stalls: got %0d want 9", s); end
    total++; if (miss_cnt !== 2 || hit_cnt !== 4) begin bad++; $display("FAIL evict cnt: got hit=%0d miss=%0d want 4/2", hit_cnt, miss_cnt); end
    total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL evict xfers left: got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_clean_evict;
    int s; logic [31:0] r;
    push_line(1'b0, 32'h100);
    access(1'b0, 32'h104, 32'h0, 3'b010, s, r);
    total++; if (r !== pat(32'h104) || s !== 5) begin bad++; $display("FAIL clean rdata/stalls: got %h/%0d want %h/5", r, s, pat(32'h104)); end
    access(1'b0, 32'h100, 32'h0, 3'b010, s, r);
    total++; if (r !== 32'hDEAD55EF) begin bad++; $display("FAIL clean wb data: got %h want DEAD55EF", r); end
    total++; if (miss_cnt !== 3 || hit_cnt !== 6) begin bad++; $display("FAIL clean cnt: got hit=%0d miss=%0d want 6/3", hit_cnt, miss_cnt); end
  endtask

  task automatic test_slow_mem;
    int s; logic [31:0] r;
    ack_delay = 5; stab_err = 0;
    push_line(1'b0, 32'h2100);
    access(1'b1, 32'h2108, 32'h1234_5678, 3'b010, s, r);
    total++; if (s < 24) begin bad++; $display("FAIL slow stalls: got %0d want >=24", s); end
    access(1'b0, 32'h2108, 32'h0, 3'b010, s, r);
    total++; if (r !== 32'h1234_5678) begin bad++; $display("FAIL slow sw rdata: got %h want 12345678", r); end
    access(1'b1, 32'h2102, 32'hABCD_1234, 3'b001, s, r);
    access(1'b0, 32'h2100, 32'h0, 3'b010, s, r);
    total++; if (r !== 32'h1234_2100) begin bad++; $display("FAIL sh rdata: got %h want 12342100", r); end
    total++; if (stab_err !== 0) begin bad++; $display("FAIL slow stability: got %0d changes want 0", stab_err); end
    total++; if (miss_cnt !== 4 || hit_cnt !== 10 || exp_q.size() !== 0) begin bad++; $display("FAIL slow cnt: got hit=%0d miss=%0d left=%0d want 10/4/0", hit_cnt, miss_cnt, exp_q.size()); end
    ack_delay = 0;
  endtask

  task automatic test_reset_mid_fill;
    int s, n; logic [31:0] r;
    ack_delay = 3;
    push_line(1'b0, 32'h3000);
    @(negedge clk);
    cpu_rd = 1'b1; cpu_wr = 1'b0; cpu_addr = 32'h3000; cpu_f3 = 3'b010;
    n = 0;
    do begin @(negedge clk); #1; n++; end while (!(mem_req === 1'b1 && mem_addr === 32'h3008) && n < 200);
    total++; if (n >= 200) begin bad++; $display("FAIL rst-fill reach word2: got addr=%h want 00003008", mem_addr); end
    rst = 1'b0;
    #1;
    total++; if (mem_req !== 1'b0 || stall !== 1'b0) begin bad++; $display("FAIL rst-fill drop: got req=%0b stall=%0b want 0/0", mem_req, stall); end
    cpu_rd = 1'b0;
    exp_q.delete();
    @(negedge clk); rst = 1'b1;
    ack_delay = 0;
    push_line(1'b0, 32'h3000);
    access(1'b0, 32'h3000, 32'h0, 3'b010, s, r);
    total++; if (r !== pat(32'h3000) || s !== 5) begin bad++; $display("FAIL rst-fill reload: got %h/%0d want %h/5", r, s, pat(32'h3000)); end
    total++; if (miss_cnt !== 1 || hit_cnt !== 1) begin bad++; $display("FAIL rst-fill cnt: got hit=%0d miss=%0d want 1/1", hit_cnt, miss_cnt); end
  endtask

  initial begin
    test_reset();
    test_cold_load();
    test_store_hit();
    test_dirty_evict();
    test_clean_evict();
    test_slow_mem();
    test_reset_mid_fill();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
